// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions.
//   - Fetch FSM state encodings (legacy-compatible localparam constants).
//   - Default bubble instruction used by the fetch stage.
package cpu_pkg;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE    = 2'd0;
  localparam fetch_state_t ST_FETCH   = 2'd1;
  localparam fetch_state_t ST_DISCARD = 2'd2;

  localparam logic [15:0] NOP_INSTR_DEFAULT = 16'h0800;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instruction} entries.
// Ports:
//   clk_i, rst_ni   - clock, asynchronous active-low reset (empties the FIFO)
//   push_i          - write push_data_i (accepted when not full, or when popping)
//   pop_i           - drop the head entry (ignored when empty)
//   flush_i         - discard all entries; wins over push/pop
//   head_o          - current head entry (valid only when !empty_o)
//   full_o, empty_o - occupancy flags
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CNT_FULL);
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  // A push at full is accepted only when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop) & ~flush_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues sequential fetches to instruction memory,
// buffers responses in a small FIFO and presents them on the IF/ID register.
// Ports:
//   CLK, RST                  - clock, asynchronous active-low reset
//   imem_req/imem_addr        - fetch request and address (held until ack)
//   imem_ack/imem_rdata       - request accepted, instruction valid this cycle
//   stall_i                   - freeze IF/ID; fetching continues until full
//   redirect_i/redirect_pc_i  - flush and restart at redirect_pc_i (beats stall)
//   step_i                    - single-step pulse
//   out_valid/out_instr/out_pc- IF/ID contents; out_pc = instruction addr + 1
// Build option: define FETCH_SINGLE_STEP_EN to advance IF/ID only on a rising
// edge of step_i; otherwise step_i is ignored.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned        ADDR_W    = 16,
  parameter int unsigned        INSTR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEFAULT),
  parameter int unsigned        QDEPTH    = 2
) (
  input  logic               CLK,
  input  logic               RST,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  input  logic               step_i,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc
);

  localparam int unsigned EW = ADDR_W + INSTR_W;

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]  disc_pc_q, disc_pc_d;
  logic [ADDR_W-1:0]  pc_inc;
  logic               out_valid_q, out_valid_d;
  logic [INSTR_W-1:0] out_instr_q, out_instr_d;
  logic [ADDR_W-1:0]  out_pc_q, out_pc_d;
  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [EW-1:0]      fifo_head;
  logic               advance;

`ifdef FETCH_SINGLE_STEP_EN
  logic step_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) step_q <= 1'b0;
    else      step_q <= step_i;
  end

  assign advance = ~stall_i & step_i & ~step_q;
`else
  logic unused_step;

  assign unused_step = step_i;
  assign advance     = ~stall_i;
`endif

  assign pc_inc = fetch_pc_q + ADDR_W'(1);

  // DISCARD keeps presenting the abandoned address until memory acks it.
  assign imem_req  = ((state_q == ST_FETCH) && !fifo_full) || (state_q == ST_DISCARD);
  assign imem_addr = (state_q == ST_DISCARD) ? disc_pc_q : fetch_pc_q;

  assign fifo_push = (state_q == ST_FETCH) && imem_req && imem_ack && !redirect_i;
  assign fifo_pop  = advance && !redirect_i;

  fetch_fifo #(
    .WIDTH(EW),
    .DEPTH(QDEPTH)
  ) u_fifo (
    .clk_i      (CLK),
    .rst_ni     (RST),
    .push_i     (fifo_push),
    .push_data_i({pc_inc, imem_rdata}),
    .pop_i      (fifo_pop),
    .flush_i    (redirect_i),
    .head_o     (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    disc_pc_d  = disc_pc_q;
    unique case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (fifo_push) fetch_pc_d = pc_inc;
        if (redirect_i && imem_req && !imem_ack) begin
          state_d   = ST_DISCARD;
          disc_pc_d = fetch_pc_q;
        end
      end
      ST_DISCARD: if (imem_ack) state_d = ST_FETCH;
      default: state_d = ST_IDLE;
    endcase
    if (redirect_i) fetch_pc_d = redirect_pc_i;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    if (redirect_i) begin
      out_valid_d = 1'b0;
      out_instr_d = NOP_INSTR;
    end else if (advance) begin
      if (!fifo_empty) begin
        {out_pc_d, out_instr_d} = fifo_head;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
        out_instr_d = NOP_INSTR;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      fetch_pc_q  <= RESET_PC;
      disc_pc_q   <= RESET_PC;
      out_valid_q <= 1'b0;
      out_instr_q <= NOP_INSTR;
      out_pc_q    <= RESET_PC;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      disc_pc_q   <= disc_pc_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model returns rdata = addr after a
// programmable number of wait cycles; a vector table covers streaming, stall
// and redirect, followed by hand sequences for the multi-cycle corner cases.
module tb_fetch_unit;

  logic        CLK, RST;
  logic        imem_req, imem_ack;
  logic [15:0] imem_addr, imem_rdata;
  logic        stall_i, redirect_i, step_i;
  logic [15:0] redirect_pc_i;
  logic        out_valid;
  logic [15:0] out_instr, out_pc;

  int total, bad;
  int mem_wait, wait_cnt, ack_cnt;
  bit mem_auto, force_ack;

  typedef struct {
    logic        st;
    logic        rd;
    logic [15:0] rpc;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_val;
    logic [15:0] e_pc;
    logic [15:0] e_ins;
  } vec_t;

  vec_t vt [17];

  fetch_unit #(
    .ADDR_W   (16),
    .INSTR_W  (16),
    .RESET_PC (16'h0000),
    .NOP_INSTR(16'h0800),
    .QDEPTH   (2)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .step_i       (step_i),
    .out_valid    (out_valid),
    .out_instr    (out_instr),
    .out_pc       (out_pc)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog");
  end

  // Memory responder: decides ack/rdata for the coming rising edge.
  always @(negedge CLK) begin
    if (!mem_auto) begin
      imem_ack   = force_ack;
      imem_rdata = 16'hBEEF;
    end else if (!RST) begin
      imem_ack = 1'b0;
      wait_cnt = 0;
    end else if (imem_req) begin
      if (wait_cnt >= mem_wait) begin
        imem_ack   = 1'b1;
        imem_rdata = imem_addr;
        wait_cnt   = 0;
        ack_cnt++;
      end else begin
        imem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      imem_ack = 1'b0;
      wait_cnt = 0;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic st, input logic rd, input logic [15:0] rpc, input logic stp);
    @(negedge CLK);
    #1;
    stall_i       = st;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    step_i        = stp;
    @(posedge CLK);
    #2;
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #2;
    RST        = 1'b0;
    stall_i    = 1'b0;
    redirect_i = 1'b0;
    step_i     = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
    RST = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},   16'(imem_req),  16'h0000);
    chk({tag, "_addr"},  imem_addr,      16'h0000);
    chk({tag, "_valid"}, 16'(out_valid), 16'h0000);
    chk({tag, "_instr"}, out_instr,      16'h0800);
    chk({tag, "_pc"},    out_pc,         16'h0000);
  endtask

  initial begin
    int n;
    int ack_base;
    bit found;
    logic [15:0] prev;

    total = 0; bad = 0;
    mem_wait = 0; wait_cnt = 0; ack_cnt = 0;
    mem_auto = 1'b1; force_ack = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0;
    RST = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; step_i = 1'b0;

    //          st    rd    rpc        req   addr       val   pc         instr
    vt[0]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0800};
    vt[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b0, 16'h0000, 16'h0800};
    vt[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1, 16'h0001, 16'h0000};
    vt[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0003, 1'b1, 16'h0002, 16'h0001};
    vt[4]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b1, 16'h0003, 16'h0002};
    vt[5]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0005, 1'b1, 16'h0003, 16'h0002};
    vt[6]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0005, 1'b1, 16'h0003, 16'h0002};
    vt[7]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0005, 1'b1, 16'h0003, 16'h0002};
    vt[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0005, 1'b1, 16'h0004, 16'h0003};
    vt[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0006, 1'b1, 16'h0005, 16'h0004};
    vt[10] = '{1'b0, 1'b1, 16'h0040, 1'b1, 16'h0040, 1'b0, 16'h0005, 16'h0800};
    vt[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0041, 1'b0, 16'h0005, 16'h0800};
    vt[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0042, 1'b1, 16'h0041, 16'h0040};
    vt[13] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0043, 1'b1, 16'h0042, 16'h0041};
    vt[14] = '{1'b1, 1'b1, 16'h0010, 1'b1, 16'h0010, 1'b0, 16'h0042, 16'h0800};
    vt[15] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0011, 1'b0, 16'h0042, 16'h0800};
    vt[16] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0012, 1'b1, 16'h0011, 16'h0010};

    repeat (2) @(posedge CLK);
    #2;
    chk_reset_vals("rst");
    @(posedge CLK);
    #2;
    RST = 1'b1;

`ifdef FETCH_SINGLE_STEP_EN
    prev = out_pc;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      cyc(1'b0, 1'b0, 16'h0000, (c == 6 || c == 7 || c == 15 || c == 16 || c == 25));
      if (out_pc !== prev) n++;
      prev = out_pc;
    end
    chk("step_changes", 16'(n), 16'd3);
    chk("step_final_pc", out_pc, 16'h0003);
    chk("step_final_valid", 16'(out_valid), 16'h0001);
`else
    // Streaming, stall, redirect with coinciding ack, redirect over stall.
    for (int i = 0; i < 17; i++) begin
      cyc(vt[i].st, vt[i].rd, vt[i].rpc, 1'b0);
      chk($sformatf("row%0d_req", i),   16'(imem_req),  16'(vt[i].e_req));
      chk($sformatf("row%0d_addr", i),  imem_addr,      vt[i].e_addr);
      chk($sformatf("row%0d_valid", i), 16'(out_valid), 16'(vt[i].e_val));
      chk($sformatf("row%0d_pc", i),    out_pc,         vt[i].e_pc);
      chk($sformatf("row%0d_instr", i), out_instr,      vt[i].e_ins);
    end

    // PC wrap at the top of the address space.
    cyc(1'b0, 1'b1, 16'hFFFF, 1'b0);
    chk("wrap_addr0", imem_addr, 16'hFFFF);
    cyc(1'b0, 1'b0, 16'h0000, 1'b0);
    chk("wrap_next_addr", imem_addr, 16'h0000);
    cyc(1'b0, 1'b0, 16'h0000, 1'b0);
    chk("wrap_out_pc", out_pc, 16'h0000);
    chk("wrap_out_instr", out_instr, 16'hFFFF);
    chk("wrap_out_valid", 16'(out_valid), 16'h0001);

    // step_i has no effect: IF/ID advances every unstalled cycle.
    for (int c = 1; c <= 4; c++) begin
      cyc(1'b0, 1'b0, 16'h0000, (c == 1 || c == 4));
      chk($sformatf("nostep_pc%0d", c), out_pc, 16'(c));
    end

    // Stall from reset release: buffer fills with exactly QDEPTH acks.
    mem_wait = 0;
    do_reset();
    ack_base = ack_cnt;
    for (int c = 0; c < 5; c++) begin
      cyc(1'b1, 1'b0, 16'h0000, 1'b0);
      chk($sformatf("stall%0d_valid", c), 16'(out_valid), 16'h0000);
      chk($sformatf("stall%0d_pc", c),    out_pc,         16'h0000);
      chk($sformatf("stall%0d_instr", c), out_instr,      16'h0800);
    end
    chk("stall_acks", 16'(ack_cnt - ack_base), 16'd2);
    chk("stall_req_off", 16'(imem_req), 16'h0000);
    cyc(1'b0, 1'b0, 16'h0000, 1'b0);
    chk("unstall_valid", 16'(out_valid), 16'h0001);
    chk("unstall_pc", out_pc, 16'h0001);
    chk("unstall_instr", out_instr, 16'h0000);

    // Redirect while a 3-wait request is outstanding.
    mem_wait = 3;
    do_reset();
    cyc(1'b0, 1'b0, 16'h0000, 1'b0);
    cyc(1'b0, 1'b1, 16'h0040, 1'b0);
    chk("disc_req", 16'(imem_req), 16'h0001);
    chk("disc_old_addr", imem_addr, 16'h0000);
    chk("disc_valid", 16'(out_valid), 16'h0000);
    n = 0;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      cyc(1'b0, 1'b0, 16'h0000, 1'b0);
      n++;
      if (imem_addr == 16'h0040) found = 1'b1;
      else chk("disc_bubble_valid", 16'(out_valid), 16'h0000);
    end
    chk("disc_cycles_to_new_addr", 16'(n), 16'd3);
    found = 1'b0;
    for (int c = 0; c < 12 && !found; c++) begin
      cyc(1'b0, 1'b0, 16'h0000, 1'b0);
      if (out_valid) found = 1'b1;
      else chk("disc_nop_instr", out_instr, 16'h0800);
    end
    chk("disc_got_valid", 16'(found), 16'h0001);
    chk("disc_first_pc", out_pc, 16'h0041);
    chk("disc_first_instr", out_instr, 16'h0040);

    // Reset mid-request; an ack arriving during IDLE must be ignored.
    chk("midrst_pending_req", 16'(imem_req), 16'h0001);
    chk("midrst_pending_addr", imem_addr, 16'h0041);
    #1;
    RST = 1'b0;
    #1;
    chk_reset_vals("midrst");
    repeat (2) @(posedge CLK);
    #2;
    force_ack = 1'b1;
    mem_auto  = 1'b0;
    mem_wait  = 0;
    RST       = 1'b1;
    @(posedge CLK);
    #2;
    mem_auto  = 1'b1;
    force_ack = 1'b0;
    chk("late_req", 16'(imem_req), 16'h0001);
    chk("late_addr", imem_addr, 16'h0000);
    chk("late_valid", 16'(out_valid), 16'h0000);
    cyc(1'b0, 1'b0, 16'h0000, 1'b0);
    chk("late_p2_valid", 16'(out_valid), 16'h0000);
    chk("late_p2_instr", out_instr, 16'h0800);
    cyc(1'b0, 1'b0, 16'h0000, 1'b0);
    chk("late_p3_valid", 16'(out_valid), 16'h0001);
    chk("late_p3_pc", out_pc, 16'h0001);
    chk("late_p3_instr", out_instr, 16'h0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
